// File: rtl/iir_ff_if.sv
// Sample-in / result-out channel of the feed-forward IIR section.
// Upstream drives x/x_valid and watches x_ready; y/y_valid is a strobe without backpressure.
interface iir_ff_if #(
   parameter int PRECISION = 16
);
   logic signed [PRECISION-1:0] x;
   logic                        x_valid;
   logic                        x_ready;
   logic signed [PRECISION-1:0] y;
   logic                        y_valid;

   modport master (output x, x_valid, input  x_ready, y, y_valid);
   modport slave  (input  x, x_valid, output x_ready, y, y_valid);
endinterface

// File: rtl/iir_ff.sv
// Feed-forward (b-coefficient) section of a direct-form-I IIR filter:
// y[n] = sat((sum b_k * x[n-k]) >>> Q), one shared MAC stepping through the M+1 taps.
module iir_ff #(
   parameter int M           = 1,
   parameter int PRECISION   = 16,
   parameter int COEFF_WIDTH = 14,
   parameter int Q           = 12
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [(M+1)*COEFF_WIDTH-1:0]   packed_b_coeffs,
   iir_ff_if.slave                        bus
);
   localparam int PW  = PRECISION + COEFF_WIDTH;
   localparam int KW  = $clog2(M + 1);
   localparam int AW  = PW + KW;
   localparam int CPW = (M + 1) * COEFF_WIDTH;

   localparam logic [KW-1:0]        K_LAST = KW'(M);
   localparam logic signed [AW-1:0] Y_MAX  = {{(AW-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
   localparam logic signed [AW-1:0] Y_MIN  = {{(AW-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

   state_e                      state_q, state_d;
   logic signed [PRECISION-1:0] taps_q [M+1];
   logic signed [PRECISION-1:0] taps_d [M+1];
   logic [CPW-1:0]              coeffs_q, coeffs_d;
   logic signed [AW-1:0]        acc_q, acc_d;
   logic [KW-1:0]               k_q, k_d;
   logic signed [PRECISION-1:0] y_q, y_d;
   logic                        y_valid_q, y_valid_d;

   logic signed [COEFF_WIDTH-1:0] b_sel;
   logic signed [PRECISION-1:0]   t_sel;
   logic signed [PW-1:0]          prod;
   logic signed [AW-1:0]          acc_shr;

   assign b_sel   = coeffs_q[k_q*COEFF_WIDTH +: COEFF_WIDTH];
   assign t_sel   = taps_q[k_q];
   // Full product of a PRECISION x COEFF_WIDTH signed multiply always fits in PW bits.
   assign prod    = PW'(b_sel) * PW'(t_sel);
   assign acc_shr = acc_q >>> Q;

   assign bus.x_ready = rst_n && (state_q == S_IDLE);
   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      taps_d    = taps_q;
      coeffs_d  = coeffs_q;
      acc_d     = acc_q;
      k_d       = k_q;
      y_d       = y_q;
      y_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.x_valid) begin
               taps_d[0] = bus.x;
               for (int i = 1; i <= M; i++) taps_d[i] = taps_q[i-1];
               coeffs_d = packed_b_coeffs;
               acc_d    = '0;
               k_d      = '0;
               state_d  = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + AW'(prod);
            k_d   = k_q + KW'(1);
            if (k_q == K_LAST) state_d = S_OUT;
         end
         S_OUT: begin
            if (acc_shr > Y_MAX)      y_d = Y_MAX[PRECISION-1:0];
            else if (acc_shr < Y_MIN) y_d = Y_MIN[PRECISION-1:0];
            else                      y_d = acc_shr[PRECISION-1:0];
            y_valid_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
      if (!rst_n) begin
         state_q   <= S_IDLE;
         taps_q    <= '{default: '0};
         acc_q     <= '0;
         k_q       <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         taps_q    <= taps_d;
         acc_q     <= acc_d;
         k_q       <= k_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   // NOTE: coefficient copy is deliberately left out of reset; it is always reloaded on sample accept before use.
   always_ff @(posedge clk) begin
      coeffs_q <= coeffs_d;
   end

endmodule

// File: tb/tb_iir_ff.sv
// Randomised self-checking bench for iir_ff (M=2) against a history-queue reference model.
module tb_iir_ff;
   localparam int M   = 2;
   localparam int P   = 16;
   localparam int CW  = 14;
   localparam int Q   = 12;
   localparam int CPW = (M + 1) * CW;
   localparam int LAT = M + 2;   // accept edge to OUT edge
   localparam int GAP = M + 3;   // one IDLE, M+1 MAC, one OUT cycle per sample

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [CPW-1:0] coeffs;

   iir_ff_if #(.PRECISION(P)) bus ();

   iir_ff #(.M(M), .PRECISION(P), .COEFF_WIDTH(CW), .Q(Q)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .packed_b_coeffs (coeffs),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_pass   = 0;
   longint hist [M+1];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [CPW-1:0] pack3(input longint b0, input longint b1, input longint b2);
      return {CW'(b2), CW'(b1), CW'(b0)};
   endfunction

   function automatic void clear_model();
      for (int k = 0; k <= M; k++) hist[k] = 0;
   endfunction

   // Reference: shift the new sample into the history, take the dot product with the
   // coefficients present at accept time, floor-divide by 2^Q and clamp.
   function automatic longint model_push(input longint xv);
      longint sum, r;
      for (int k = M; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = xv;
      sum = 0;
      for (int k = 0; k <= M; k++) sum += longint'($signed(coeffs[k*CW +: CW])) * hist[k];
      r = sum >>> Q;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   function automatic longint rand_c();
      return longint'($urandom_range(0, (1 << CW) - 1)) - (1 << (CW - 1));
   endfunction

   function automatic longint rand_x();
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         default: return longint'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      @(negedge clk);
   endtask

   // Offer one sample, optionally change coefficients mid-computation and/or pulse a
   // stray x_valid while busy, then check latency, value and one-cycle strobe.
   task automatic send(input string tag, input longint xv, input bit chg,
                       input logic [CPW-1:0] new_c, input bit glitch, output longint got);
      int     n, lat;
      longint e;
      n = 0;
      while (!bus.x_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, bus.x_ready, 1);
      bus.x       = P'(xv);
      bus.x_valid = 1'b1;
      e = model_push(xv);
      @(negedge clk);
      bus.x_valid = 1'b0;
      if (chg) coeffs = new_c;
      lat = 0;
      while (!bus.y_valid && lat < 20) begin
         if (glitch && lat == 1) begin
            bus.x_valid = 1'b1;
            bus.x       = P'($urandom);
         end
         @(negedge clk);
         lat++;
         bus.x_valid = 1'b0;
      end
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_y"}, $signed(bus.y), e);
      got = $signed(bus.y);
      @(negedge clk);
      check({tag, "_strobe"}, bus.y_valid, 0);
      check({tag, "_hold"}, $signed(bus.y), e);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      longint   got;
      longint   imp_exp [5];
      longint   expq [$];
      int       seen, accepts, cyc, last;
      bit       just_acc;
      longint   e;

      bus.x       = '0;
      bus.x_valid = 1'b0;
      coeffs      = pack3(2048, 2048, 0);
      clear_model();

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_xready_low", bus.x_ready, 0);
      check("rst_y", $signed(bus.y), 0);
      check("rst_yvalid", bus.y_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_xready", bus.x_ready, 1);
      check("rel_y", $signed(bus.y), 0);
      check("rel_yvalid", bus.y_valid, 0);

      // Two-tap moving average (b_2 = 0), floor truncation on negatives
      send("ma0", -3, 0, '0, 0, got);
      check("ma0_const", got, -2);
      send("ma1", 2, 0, '0, 0, got);
      check("ma1_const", got, -1);
      send("ma2", 0, 0, '0, 0, got);
      check("ma2_const", got, 1);

      // Impulse response
      coeffs = pack3(1024, 2048, 4096);
      do_reset();
      imp_exp = '{1024, 2048, 4096, 0, 0};
      for (int i = 0; i < 5; i++) begin
         send("imp", (i == 0) ? 4096 : 0, 0, '0, 0, got);
         check("imp_const", got, imp_exp[i]);
      end

      // Saturation both ways
      coeffs = pack3(8191, 8191, 0);
      do_reset();
      send("satp0", 32767, 0, '0, 0, got);
      send("satp1", 32767, 0, '0, 0, got);
      check("satp_const", got, 32767);
      send("satn0", -32768, 0, '0, 0, got);
      send("satn1", -32768, 0, '0, 0, got);
      check("satn_const", got, -32768);

      // Stray x_valid while busy must leave the taps alone
      coeffs = pack3(1024, -2048, 3000);
      for (int i = 0; i < 4; i++) send("ign", rand_x(), 0, '0, 1, got);

      // Coefficient change mid-MAC: current result old set, next result new set
      coeffs = pack3(4096, 0, 0);
      send("clatch_old", 1000, 1, pack3(0, 4096, 0), 0, got);
      check("clatch_old_const", got, 1000);
      send("clatch_new", 77, 0, '0, 0, got);
      check("clatch_new_const", got, 1000);

      // Reset in the middle of MAC aborts the sample and clears history
      coeffs = pack3(4096, 4096, 4096);
      send("pre_rst", 3000, 0, '0, 0, got);
      bus.x       = P'(1234);
      bus.x_valid = 1'b1;
      @(negedge clk);
      bus.x_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_xready", bus.x_ready, 0);
      check("midrst_y", $signed(bus.y), 0);
      rst_n = 1'b1;
      clear_model();
      seen = 0;
      repeat (LAT + 1) begin
         @(negedge clk);
         if (bus.y_valid) seen++;
      end
      check("midrst_no_yvalid", seen, 0);
      send("post_rst", 5000, 0, '0, 0, got);
      check("post_rst_const", got, 5000);

      // Random samples, coefficients, mid-flight changes and stray pulses
      coeffs = pack3(rand_c(), rand_c(), rand_c());
      for (int i = 0; i < 24; i++)
         send("rnd", rand_x(), 1'($urandom_range(0, 1)), pack3(rand_c(), rand_c(), rand_c()),
              1'($urandom_range(0, 1)), got);

      // x_valid held high: one accept every GAP cycles, nothing lost or duplicated
      bus.x       = P'(rand_x());
      bus.x_valid = 1'b1;
      accepts     = 0;
      cyc         = 0;
      last        = 0;
      just_acc    = 1'b0;
      while ((accepts < 12 || expq.size() > 0) && cyc < 2000) begin
         if (bus.y_valid) begin
            if (expq.size() > 0) check("stream_y", $signed(bus.y), expq.pop_front());
            else check("stream_extra_yvalid", bus.y_valid, 0);
         end
         if (accepts < 12 && bus.x_ready) begin
            e = model_push(longint'(bus.x));
            expq.push_back(e);
            if (accepts > 0) check("stream_gap", cyc - last, GAP);
            last     = cyc;
            accepts++;
            just_acc = 1'b1;
         end else if (accepts >= 12) begin
            bus.x_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (just_acc) begin
            bus.x    = P'(rand_x());
            just_acc = 1'b0;
         end
      end
      bus.x_valid = 1'b0;
      check("stream_accepts", accepts, 12);
      check("stream_drained", expq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
